// File: rtl/video_timing_pipe_pkg.sv
// Shared timing description for video_timing_pipe: mode struct, the 720p60 mode
// constant and helpers deriving line/frame totals and counter widths.
package video_timing_pkg;

    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
    } timing_t;

    localparam timing_t TIMING_720P60 = '{
        h_active: 1280, h_fp: 110, h_sync: 40, h_bp: 220,
        v_active: 720,  v_fp: 5,   v_sync: 5,  v_bp: 20
    };

    localparam int FC_MAX_DEFAULT = 60;

    function automatic int h_total(input timing_t t);
        return t.h_active + t.h_fp + t.h_sync + t.h_bp;
    endfunction

    function automatic int v_total(input timing_t t);
        return t.v_active + t.v_fp + t.v_sync + t.v_bp;
    endfunction

    // A modulus of 1 still needs a one-bit counter to keep port widths legal.
    function automatic int counter_width(input int modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

endpackage

// File: rtl/video_timing_pipe_pipeline.sv
// Fixed-length register delay line; every stage clears on synchronous active-low reset.
module pipeline #(
    parameter int STAGES = 1,
    parameter int WIDTH  = 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] stage_d [STAGES];

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign stage_d[gi] = d_in;
            end else begin : g_body
                assign stage_d[gi] = stage_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign q_out = stage_q[STAGES-1];

endmodule

// File: rtl/video_timing_pipe.sv
// Video timing generator issuing frame-buffer fetch coordinates and emitting latency-aligned
// pixels with sync/active/new-frame. Define VIDEO_TIMING_PIPE_TESTPAT_EN for colour bars.
module video_timing_pipe
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE   = TIMING_720P60.h_active,
    parameter int H_FP       = TIMING_720P60.h_fp,
    parameter int H_SYNC     = TIMING_720P60.h_sync,
    parameter int H_BP       = TIMING_720P60.h_bp,
    parameter int V_ACTIVE   = TIMING_720P60.v_active,
    parameter int V_FP       = TIMING_720P60.v_fp,
    parameter int V_SYNC     = TIMING_720P60.v_sync,
    parameter int V_BP       = TIMING_720P60.v_bp,
    parameter int SYNC_POL   = 1,
    parameter int SCALE_LOG2 = 0,
    parameter int FETCH_LAT  = 3,
    parameter int CHANNELS   = 3,
    parameter int CH_WIDTH   = 8,
    parameter int FC_MAX     = FC_MAX_DEFAULT,
    localparam timing_t MODE = '{
        h_active: H_ACTIVE, h_fp: H_FP, h_sync: H_SYNC, h_bp: H_BP,
        v_active: V_ACTIVE, v_fp: V_FP, v_sync: V_SYNC, v_bp: V_BP
    },
    localparam int H_TOTAL = h_total(MODE),
    localparam int V_TOTAL = v_total(MODE),
    localparam int HW      = $clog2(H_TOTAL),
    localparam int VW      = $clog2(V_TOTAL),
    localparam int PW      = CHANNELS * CH_WIDTH,
    localparam int FCW     = counter_width(FC_MAX)
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   en_in,
`ifdef VIDEO_TIMING_PIPE_TESTPAT_EN
    input  logic                   pattern_in,
`endif
    output logic [HW-SCALE_LOG2-1:0] fb_x_out,
    output logic [VW-SCALE_LOG2-1:0] fb_y_out,
    output logic                   fb_req_out,
    input  logic [PW-1:0]          fb_data_in,
    output logic [HW-1:0]          hcount_out,
    output logic [VW-1:0]          vcount_out,
    output logic                   hs_out,
    output logic                   vs_out,
    output logic                   ad_out,
    output logic                   nf_out,
    output logic [FCW-1:0]         fc_out,
    output logic [PW-1:0]          pix_out
);

    localparam logic [HW-1:0]  H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0]  V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [FCW-1:0] FC_LAST   = FCW'(FC_MAX - 1);
    localparam int             HS_START  = H_ACTIVE + H_FP;
    localparam int             HS_END    = H_ACTIVE + H_FP + H_SYNC;
    localparam int             VS_START  = V_ACTIVE + V_FP;
    localparam int             VS_END    = V_ACTIVE + V_FP + V_SYNC;
    localparam logic           SYNC_LVL  = (SYNC_POL != 0);

    generate
        if ((H_ACTIVE % (1 << SCALE_LOG2)) != 0 || (V_ACTIVE % (1 << SCALE_LOG2)) != 0) begin : g_bad_scale
            $error("video_timing_pipe: active area not divisible by upscale factor");
        end
        if (FETCH_LAT < 1) begin : g_bad_lat
            $error("video_timing_pipe: FETCH_LAT must be at least 1");
        end
    endgenerate

    // Sync travels as an active-high flag so an all-zero (reset) delay line means deasserted.
    typedef struct packed {
        logic [HW-1:0] h;
        logic [VW-1:0] v;
        logic          hs;
        logic          vs;
        logic          ad;
        logic          nf;
    } tap_t;

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          ad0, hs0, vs0, nf0;
    logic          pattern_sel;
    tap_t          tap_in, tap_out;

    logic [HW-1:0]  hcount_q, hcount_d;
    logic [VW-1:0]  vcount_q, vcount_d;
    logic           hs_act_q, hs_act_d;
    logic           vs_act_q, vs_act_d;
    logic           ad_q, ad_d;
    logic           nf_q, nf_d;
    logic [FCW-1:0] fc_q, fc_d;
    logic [PW-1:0]  pix_q, pix_d;
    logic [PW-1:0]  bar_pix;

`ifdef VIDEO_TIMING_PIPE_TESTPAT_EN
    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    logic [2:0] bar_k;

    assign pattern_sel = pattern_in;
    assign bar_k       = 3'(int'(tap_out.h) / BAR_W);

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_bar
            if (gi < 3) begin : g_on
                assign bar_pix[gi*CH_WIDTH +: CH_WIDTH] = {CH_WIDTH{bar_k[gi]}};
            end else begin : g_off
                assign bar_pix[gi*CH_WIDTH +: CH_WIDTH] = '0;
            end
        end
    endgenerate
`else
    assign pattern_sel = 1'b0;
    assign bar_pix     = '0;
`endif

    // Stage 0: raster position; holds while en_in is low.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (en_in) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
            end else begin
                h_d = h_q + HW'(1);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    always_comb begin
        ad0 = (int'(h_q) < H_ACTIVE) && (int'(v_q) < V_ACTIVE);
        hs0 = (int'(h_q) >= HS_START) && (int'(h_q) < HS_END);
        vs0 = (int'(v_q) >= VS_START) && (int'(v_q) < VS_END);
        nf0 = (int'(h_q) == H_ACTIVE) && (int'(v_q) == V_ACTIVE);
    end

    assign fb_x_out   = h_q[HW-1:SCALE_LOG2];
    assign fb_y_out   = v_q[VW-1:SCALE_LOG2];
    assign fb_req_out = ad0 && en_in && !pattern_sel;

    // A stalled position enters the delay line as blanking so the held pixel is drawn only once.
    always_comb begin
        tap_in    = '0;
        tap_in.h  = h_q;
        tap_in.v  = v_q;
        tap_in.hs = hs0;
        tap_in.vs = vs0;
        tap_in.ad = ad0 && en_in;
        tap_in.nf = nf0 && en_in;
    end

    pipeline #(
        .STAGES (FETCH_LAT),
        .WIDTH  ($bits(tap_t))
    ) u_delay (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .d_in   (tap_in),
        .q_out  (tap_out)
    );

    always_comb begin
        hcount_d = tap_out.h;
        vcount_d = tap_out.v;
        hs_act_d = tap_out.hs;
        vs_act_d = tap_out.vs;
        ad_d     = tap_out.ad;
        nf_d     = tap_out.nf;
        pix_d    = '0;
        if (tap_out.ad) begin
            pix_d = pattern_sel ? bar_pix : fb_data_in;
        end
        fc_d = fc_q;
        if (nf_q) begin
            fc_d = (fc_q == FC_LAST) ? '0 : fc_q + FCW'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            hcount_q <= '0;
            vcount_q <= '0;
            hs_act_q <= 1'b0;
            vs_act_q <= 1'b0;
            ad_q     <= 1'b0;
            nf_q     <= 1'b0;
            fc_q     <= '0;
            pix_q    <= '0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hs_act_q <= hs_act_d;
            vs_act_q <= vs_act_d;
            ad_q     <= ad_d;
            nf_q     <= nf_d;
            fc_q     <= fc_d;
            pix_q    <= pix_d;
        end
    end

    assign hcount_out = hcount_q;
    assign vcount_out = vcount_q;
    assign hs_out     = hs_act_q ? SYNC_LVL : ~SYNC_LVL;
    assign vs_out     = vs_act_q ? SYNC_LVL : ~SYNC_LVL;
    assign ad_out     = ad_q;
    assign nf_out     = nf_q;
    assign fc_out     = fc_q;
    assign pix_out    = pix_q;

endmodule

// File: tb/tb_video_timing_pipe.sv
// Directed bench for video_timing_pipe in a 14x7 mode with a 2-cycle echo frame buffer.
module tb_video_timing_pipe;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        pattern;
    logic [3:0]  fb_x;
    logic [2:0]  fb_y;
    logic        fb_req;
    logic [23:0] fb_data;
    logic [3:0]  hcount;
    logic [2:0]  vcount;
    logic        hs, vs, ad, nf;
    logic [5:0]  fc;
    logic [23:0] pix;

    logic [2:0]  s_fb_x;
    logic [1:0]  s_fb_y;
    logic        s_fb_req;
    logic [23:0] s_fb_data;
    logic [3:0]  s_hcount;
    logic [2:0]  s_vcount;
    logic        s_hs, s_vs, s_ad, s_nf;
    logic [5:0]  s_fc;
    logic [23:0] s_pix;
    logic        s_pattern;

    int checks = 0;
    int fails  = 0;

    typedef struct packed {
        logic [3:0]  h;
        logic [2:0]  v;
        logic        hs;
        logic        vs;
        logic        ad;
        logic        nf;
        logic [23:0] pix;
    } exp_t;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    video_timing_pipe #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1), .SCALE_LOG2(0), .FETCH_LAT(2),
        .CHANNELS(3), .CH_WIDTH(8), .FC_MAX(60)
    ) u_dut (
        .clk_in     (clk),
        .rst_in     (rst_n),
        .en_in      (en),
`ifdef VIDEO_TIMING_PIPE_TESTPAT_EN
        .pattern_in (pattern),
`endif
        .fb_x_out   (fb_x),
        .fb_y_out   (fb_y),
        .fb_req_out (fb_req),
        .fb_data_in (fb_data),
        .hcount_out (hcount),
        .vcount_out (vcount),
        .hs_out     (hs),
        .vs_out     (vs),
        .ad_out     (ad),
        .nf_out     (nf),
        .fc_out     (fc),
        .pix_out    (pix)
    );

    video_timing_pipe #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1), .SCALE_LOG2(1), .FETCH_LAT(2),
        .CHANNELS(3), .CH_WIDTH(8), .FC_MAX(60)
    ) u_scl (
        .clk_in     (clk),
        .rst_in     (rst_n),
        .en_in      (en),
`ifdef VIDEO_TIMING_PIPE_TESTPAT_EN
        .pattern_in (s_pattern),
`endif
        .fb_x_out   (s_fb_x),
        .fb_y_out   (s_fb_y),
        .fb_req_out (s_fb_req),
        .fb_data_in (s_fb_data),
        .hcount_out (s_hcount),
        .vcount_out (s_vcount),
        .hs_out     (s_hs),
        .vs_out     (s_vs),
        .ad_out     (s_ad),
        .nf_out     (s_nf),
        .fc_out     (s_fc),
        .pix_out    (s_pix)
    );

    assign s_fb_data = 24'h0;
    assign s_pattern = 1'b0;

    // Frame buffer echo: returns {0, x, y} two cycles after the coordinates are presented.
    logic [23:0] lat1, lat2;
    always @(posedge clk) begin
        lat1 <= {8'h00, 4'h0, fb_x, 5'h00, fb_y};
        lat2 <= lat1;
    end
    assign fb_data = lat2;

    // Expected aligned outputs n cycles after reset release (continuous run, 3-cycle lag).
    function automatic exp_t exp_at(input int n);
        exp_t e;
        int s, h, v;
        e = '0;
        if (n >= 3) begin
            s = n - 3;
            h = s % 14;
            v = (s / 14) % 7;
            e.h   = 4'(h);
            e.v   = 3'(v);
            e.hs  = (h >= 10 && h < 12);
            e.vs  = (v == 5);
            e.ad  = (h < 8 && v < 4);
            e.nf  = (h == 8 && v == 4);
            e.pix = e.ad ? {8'h00, 8'(h), 8'(v)} : 24'h0;
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (hcount !== 4'd0 || vcount !== 3'd0) begin
            fails++;
            $display("FAIL reset_counts: got h=%0d v=%0d, expected h=0 v=0", hcount, vcount);
        end
        checks++;
        if ({hs, vs, ad, nf} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_flags: got hs/vs/ad/nf=%b, expected 0000", {hs, vs, ad, nf});
        end
        checks++;
        if (fc !== 6'd0 || pix !== 24'h0) begin
            fails++;
            $display("FAIL reset_fc_pix: got fc=%0d pix=%h, expected fc=0 pix=000000", fc, pix);
        end
        checks++;
        if ({fb_x, fb_y, fb_req} !== {4'd0, 3'd0, 1'b1}) begin
            fails++;
            $display("FAIL reset_fetch: got x=%0d y=%0d req=%b, expected x=0 y=0 req=1", fb_x, fb_y, fb_req);
        end
        $display("test_reset: done, %0d failures so far", fails);
    endtask

    task automatic test_frame();
        exp_t e, o;
        int   h, v, ad_cnt, hs_cnt, vs_cnt, nf_cnt, shown;
        logic req_e;
        ad_cnt = 0; hs_cnt = 0; vs_cnt = 0; nf_cnt = 0; shown = 0;
        do_reset();
        for (int n = 0; n < 3 + 2 * 98; n++) begin
            e = exp_at(n);
            o = {hcount, vcount, hs, vs, ad, nf, pix};
            checks++;
            if (o !== e) begin
                fails++;
                if (shown++ < 8)
                    $display("FAIL frame_aligned n=%0d: got h=%0d v=%0d hs=%b vs=%b ad=%b nf=%b pix=%h, expected h=%0d v=%0d hs=%b vs=%b ad=%b nf=%b pix=%h",
                             n, o.h, o.v, o.hs, o.vs, o.ad, o.nf, o.pix, e.h, e.v, e.hs, e.vs, e.ad, e.nf, e.pix);
            end
            h = n % 14;
            v = (n / 14) % 7;
            req_e = (h < 8 && v < 4);
            checks++;
            if ({fb_x, fb_y, fb_req} !== {4'(h), 3'(v), req_e}) begin
                fails++;
                if (shown++ < 8)
                    $display("FAIL frame_fetch n=%0d: got x=%0d y=%0d req=%b, expected x=%0d y=%0d req=%b",
                             n, fb_x, fb_y, fb_req, h, v, req_e);
            end
            if (n >= 3 && n < 101) begin
                ad_cnt += int'(ad);
                hs_cnt += int'(hs);
                vs_cnt += int'(vs);
                nf_cnt += int'(nf);
            end
            step();
        end
        checks++;
        if (ad_cnt != 32) begin
            fails++;
            $display("FAIL frame_ad_count: got %0d, expected 32", ad_cnt);
        end
        checks++;
        if (hs_cnt != 14) begin
            fails++;
            $display("FAIL frame_hs_count: got %0d, expected 14", hs_cnt);
        end
        checks++;
        if (vs_cnt != 14) begin
            fails++;
            $display("FAIL frame_vs_count: got %0d, expected 14", vs_cnt);
        end
        checks++;
        if (nf_cnt != 1) begin
            fails++;
            $display("FAIL frame_nf_count: got %0d, expected 1", nf_cnt);
        end
        $display("test_frame: done, %0d failures so far", fails);
    endtask

    task automatic test_fc();
        int         fc_exp, wraps, shown;
        logic [5:0] fc_prev;
        fc_exp = 0; wraps = 0; shown = 0; fc_prev = 6'd0;
        do_reset();
        for (int n = 0; n < 60 * 98 + 90; n++) begin
            checks++;
            if (fc !== 6'(fc_exp)) begin
                fails++;
                if (shown++ < 8)
                    $display("FAIL fc_value n=%0d: got %0d, expected %0d", n, fc, fc_exp);
            end
            if (fc_prev == 6'd59 && fc == 6'd0) wraps++;
            fc_prev = fc;
            if (exp_at(n).nf) fc_exp = (fc_exp == 59) ? 0 : fc_exp + 1;
            step();
        end
        checks++;
        if (wraps != 1) begin
            fails++;
            $display("FAIL fc_wrap: got %0d wraps 59->0, expected 1", wraps);
        end
        $display("test_fc: done, %0d failures so far", fails);
    endtask

    task automatic test_enable();
        int          exp_hc [9] = '{2, 3, 3, 3, 3, 3, 3, 4, 5};
        logic        exp_ad [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [23:0] exp_pix;
        do_reset();
        repeat (17) step();
        for (int n = 17; n <= 27; n++) begin
            if (n == 17) en = 1'b0;
            if (n == 22) en = 1'b1;
            #1;
            if (n <= 21) begin
                checks++;
                if ({fb_x, fb_y, fb_req} !== {4'd3, 3'd1, 1'b0}) begin
                    fails++;
                    $display("FAIL enable_hold n=%0d: got x=%0d y=%0d req=%b, expected x=3 y=1 req=0",
                             n, fb_x, fb_y, fb_req);
                end
            end
            if (n >= 19) begin
                exp_pix = exp_ad[n-19] ? {8'h00, 8'(exp_hc[n-19]), 8'd1} : 24'h0;
                checks++;
                if ({hcount, vcount, ad, nf, pix} !== {4'(exp_hc[n-19]), 3'd1, exp_ad[n-19], 1'b0, exp_pix}) begin
                    fails++;
                    $display("FAIL enable_aligned n=%0d: got h=%0d v=%0d ad=%b nf=%b pix=%h, expected h=%0d v=1 ad=%b nf=0 pix=%h",
                             n, hcount, vcount, ad, nf, pix, exp_hc[n-19], exp_ad[n-19], exp_pix);
                end
            end
            step();
        end
        $display("test_enable: done, %0d failures so far", fails);
    endtask

    task automatic test_midframe_reset();
        exp_t e, o;
        int   nf_cnt, shown;
        nf_cnt = 0; shown = 0;
        do_reset();
        repeat (33) step();
        checks++;
        if ({fb_x, fb_y} !== {4'd5, 3'd2}) begin
            fails++;
            $display("FAIL midreset_pos: got x=%0d y=%0d, expected x=5 y=2", fb_x, fb_y);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if ({hcount, vcount, hs, vs, ad, nf, fc, pix, fb_x, fb_y} !== {4'd0, 3'd0, 4'b0000, 6'd0, 24'h0, 4'd0, 3'd0}) begin
            fails++;
            $display("FAIL midreset_state: got h=%0d v=%0d hs=%b vs=%b ad=%b nf=%b fc=%0d pix=%h x=%0d y=%0d, expected all zero",
                     hcount, vcount, hs, vs, ad, nf, fc, pix, fb_x, fb_y);
        end
        for (int n = 0; n < 102; n++) begin
            e = exp_at(n);
            o = {hcount, vcount, hs, vs, ad, nf, pix};
            checks++;
            if (o !== e) begin
                fails++;
                if (shown++ < 8)
                    $display("FAIL midreset_restart n=%0d: got h=%0d v=%0d ad=%b nf=%b pix=%h, expected h=%0d v=%0d ad=%b nf=%b pix=%h",
                             n, o.h, o.v, o.ad, o.nf, o.pix, e.h, e.v, e.ad, e.nf, e.pix);
            end
            nf_cnt += int'(nf);
            step();
        end
        checks++;
        if (nf_cnt != 1) begin
            fails++;
            $display("FAIL midreset_nf_count: got %0d, expected 1", nf_cnt);
        end
        $display("test_midframe_reset: done, %0d failures so far", fails);
    endtask

    task automatic test_scale();
        int tx [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
        int ty [4] = '{0, 0, 1, 1};
        int h, v, ad_cnt, shown;
        ad_cnt = 0; shown = 0;
        do_reset();
        for (int n = 0; n < 101; n++) begin
            h = n % 14;
            v = n / 14;
            if (n < 98 && h < 8 && v < 4) begin
                checks++;
                if ({s_fb_x, s_fb_y, s_fb_req} !== {3'(tx[h]), 2'(ty[v]), 1'b1}) begin
                    fails++;
                    if (shown++ < 8)
                        $display("FAIL scale_fetch n=%0d: got x=%0d y=%0d req=%b, expected x=%0d y=%0d req=1",
                                 n, s_fb_x, s_fb_y, s_fb_req, tx[h], ty[v]);
                end
            end else if (n < 98) begin
                checks++;
                if (s_fb_req !== 1'b0) begin
                    fails++;
                    if (shown++ < 8)
                        $display("FAIL scale_blank_req n=%0d: got %b, expected 0", n, s_fb_req);
                end
            end
            if (n >= 3) ad_cnt += int'(s_ad);
            step();
        end
        checks++;
        if (ad_cnt != 32) begin
            fails++;
            $display("FAIL scale_ad_count: got %0d, expected 32", ad_cnt);
        end
        $display("test_scale: done, %0d failures so far", fails);
    endtask

`ifdef VIDEO_TIMING_PIPE_TESTPAT_EN
    task automatic test_testpat();
        exp_t        e;
        logic [23:0] exp_pix;
        int          shown;
        shown = 0;
        do_reset();
        pattern = 1'b1;
        for (int n = 0; n < 101; n++) begin
            #1;
            e = exp_at(n);
            exp_pix = e.ad ? {{8{e.h[2]}}, {8{e.h[1]}}, {8{e.h[0]}}} : 24'h0;
            checks++;
            if ({fb_req, pix} !== {1'b0, exp_pix}) begin
                fails++;
                if (shown++ < 8)
                    $display("FAIL testpat n=%0d: got req=%b pix=%h, expected req=0 pix=%h", n, fb_req, pix, exp_pix);
            end
            step();
        end
        pattern = 1'b0;
        $display("test_testpat: done, %0d failures so far", fails);
    endtask
`endif

    initial begin
        rst_n   = 1'b0;
        en      = 1'b1;
        pattern = 1'b0;
        test_reset();
        test_frame();
        test_fc();
        test_enable();
        test_midframe_reset();
        test_scale();
`ifdef VIDEO_TIMING_PIPE_TESTPAT_EN
        test_testpat();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/video_timing_pipe.md
Name: video_timing_pipe

Overview:
- Parametrised successor to the fixed 720p HDMI front end.
- Generates video timing for any mode and issues frame-buffer fetch coordinates, with optional integer upscaling.
- Absorbs a configurable frame-buffer read latency. Emits pixel data aligned with sync, active-draw and new-frame, ready for the TMDS encoders.
- Sits between the frame-buffer read port and the encoder/serializer stage, all in the pixel clock domain.

Parameters:
H_ACTIVE, 1280, active pixels per line
H_FP, 110, horizontal front porch (cycles)
H_SYNC, 40, horizontal sync width
H_BP, 220, horizontal back porch
V_ACTIVE, 720, active lines per frame
V_FP, 5, vertical front porch (lines)
V_SYNC, 5, vertical sync width
V_BP, 20, vertical back porch
SYNC_POL, 1, asserted level of hs_out/vs_out
SCALE_LOG2, 0, upscale factor 2^SCALE_LOG2 in both axes
FETCH_LAT, 3, cycles from fb_x/fb_y to valid fb_data_in (>=1)
CHANNELS, 3, colour channels
CH_WIDTH, 8, bits per channel
FC_MAX, 60, frame counter modulus

Ports:
clk_in  in  1  pixel clock
rst_in  in  1  synchronous active-low reset
en_in  in  1  timing run enable
fb_x_out  out  HW-SCALE_LOG2  frame-buffer column (hcount>>SCALE_LOG2)
fb_y_out  out  VW-SCALE_LOG2  frame-buffer row (vcount>>SCALE_LOG2)
fb_req_out  out  1  fetch strobe; high when stage-0 position is active
fb_data_in  in  CHANNELS*CH_WIDTH  pixel returned FETCH_LAT cycles after request; channel 0 in the LSBs
hcount_out  out  HW  aligned horizontal count
vcount_out  out  VW  aligned vertical count
hs_out  out  1  aligned horizontal sync
vs_out  out  1  aligned vertical sync
ad_out  out  1  aligned active draw
nf_out  out  1  aligned single-cycle new-frame pulse
fc_out  out  $clog2(FC_MAX)  frame counter
pix_out  out  CHANNELS*CH_WIDTH  aligned pixel, zero outside active

Behaviour:
- H_TOTAL = sum of the H_* parameters; V_TOTAL = sum of the V_* parameters. HW = $clog2(H_TOTAL), VW = $clog2(V_TOTAL).
- Stage 0 counters:
  - h wraps H_TOTAL-1 -> 0.
  - v increments on h wrap and wraps V_TOTAL-1 -> 0.
  - On the last cycle of a frame (h=H_TOTAL-1, v=V_TOTAL-1) both counters wrap together.
- Stage 0 signals:
  - ad0 = (h<H_ACTIVE) && (v<V_ACTIVE).
  - hs0 = SYNC_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else ~SYNC_POL; vs0 likewise on v.
  - nf0 = (h==H_ACTIVE && v==V_ACTIVE).
- fb_x_out, fb_y_out and fb_req_out are combinational from stage 0. fb_req_out = ad0 && en_in.
- Delay line: h, v, hs0, vs0, ad0 and nf0 are delayed FETCH_LAT cycles, then a final register captures pix_out = ad ? fb_data_in : 0.
  - Every aligned output therefore lags stage 0 by FETCH_LAT+1 cycles.
  - pix_out at cycle t+FETCH_LAT+1 corresponds to the request at cycle t.
- fc_out increments on the aligned nf_out cycle and wraps FC_MAX-1 -> 0.
- en_in low:
  - Counters hold.
  - ad0 and nf0 are forced to 0 at delay-line entry; hs0/vs0 keep their held values.
  - The delay line keeps shifting and drains. Resuming en_in continues from the held position.
- Reset (rst_in low at a clock edge):
  - Counters, delay line, hcount_out, vcount_out, ad_out, nf_out, fc_out and pix_out all go to 0.
  - hs_out and vs_out go to ~SYNC_POL.
  - Mid-frame reset restarts at h=v=0 on the cycle after release; no partial nf pulse is emitted.
- Upscale: each fb pixel repeats 2^SCALE_LOG2 times horizontally and on 2^SCALE_LOG2 consecutive lines. H_ACTIVE and V_ACTIVE must be divisible by 2^SCALE_LOG2; an elaboration-time assertion enforces this.

Optional Feature:
- Macro: VIDEO_TIMING_PIPE_TESTPAT_EN.
- When defined:
  - Adds input pattern_in (1 bit).
  - When pattern_in is high, pix_out shows 8 vertical colour bars of width H_ACTIVE/8. Bar index k = hcount_out/(H_ACTIVE/8); channel c is all-ones if bit c of k is set, else zero.
  - fb_data_in is ignored and fb_req_out stays low while pattern_in is high.
- When undefined: no pattern_in port, and pix_out is always sourced from fb_data_in.

Decomposition:
- Package video_timing_pkg holds:
  - a timing-struct typedef (active, fp, sync, bp per axis);
  - a 720p60 localparam constant of that typedef;
  - a function computing totals.
- Delays reuse the existing pipeline module (STAGES=FETCH_LAT). No new sub-module.

Test Plan:
- Small mode: H=8/2/2/2, V=4/1/1/1, FETCH_LAT=2, SCALE_LOG2=0, fb_data_in = {h,v} echo model → ad_out high for exactly 32 cycles/frame; pix_out matches request 3 cycles earlier; hs_out high for 2 cycles at aligned h=10..11.
- Same mode → nf_out pulses once per 98 cycles (H_TOTAL 14 × V_TOTAL 7), when aligned h=8, v=4; fc_out counts 0..59 then wraps to 0.
- SCALE_LOG2=1 → fb_x_out sequence 0,0,1,1,2,2,3,3 per line; fb_y_out repeats each value for 2 lines.
- Drop en_in for 5 cycles mid-line → counters frozen, ad_out low for 5 cycles after the 3-cycle lag, no pixel skipped on resume.
- Assert rst_in low mid-frame (v=2) for 1 cycle → all outputs at reset values next cycle, restart from h=v=0, no spurious nf_out.
- TESTPAT_EN defined, pattern_in=1, H_ACTIVE=8 → pix_out channel 0 all-ones at odd hcount_out, fb_req_out stays 0.
